seq_auction: RTL and testbench
==============================

Name: seq_auction

Overview:
- Sequential, parametrised sealed-bid auction engine; successor to the combinational argmax-tree auction.
- Accepts one bid per cycle over a valid/ready stream and tracks the highest and second-highest bids.
- On close, reports the winner index and clearing price in first-price or second-price (Vickrey) mode.
- Sits between a bid-source FIFO and the result consumer; used as the baseline circuit for larger party counts, where a full comparator tree is too wide.

Parameters:
- N, 2, log2 of max bidders; bidder index width is N; max bidders per auction is 2**N.
- W, 8, bid/price width in bits, unsigned.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  opens an auction; sampled only in IDLE or DONE.
- mode  input  1  0 = first-price, 1 = second-price; latched on accepted start.
- bid_valid  input  1  bid present.
- bid_ready  output  1  high only in COLLECT.
- bid  input  W  bid value.
- bid_last  input  1  marks the final bid of this auction.
- busy  output  1  high in COLLECT.
- done  output  1  one-cycle pulse when a result becomes valid.
- winner  output  N  winning bidder index (arrival order, 0-based).
- price  output  W  clearing price.
- num_bids  output  N+1  number of bids accepted in the last auction.

Behaviour:
- Reset (asynchronous): state = IDLE; bid_ready, busy, done = 0; winner, price, num_bids = 0; internal top1, top2, count, mode_r = 0.
- States: IDLE, COLLECT, DONE.
  - IDLE/DONE + start: go to COLLECT. Clear top1/top2/idx/count to 0 and latch mode.
  - IDLE/DONE without start: hold. winner/price/num_bids stay stable until the next accepted start.
  - COLLECT: a bid is accepted when bid_valid && bid_ready. On acceptance, with index = count:
    - bid > top1: top2 <= top1; top1 <= bid; idx <= count.
    - else if bid > top2: top2 <= bid.
    - Tie with top1: the earlier bidder keeps the win, and top2 <= bid (equal second price).
    - count increments.
  - COLLECT exits when the accepted bid has bid_last = 1, or count reaches 2**N (the 2**N-th accepted bid forces close regardless of bid_last).
- Exit timing: next cycle state = DONE.
  - winner <= idx, including the update from the final bid.
  - price <= top1 if mode_r = 0, else top2.
  - num_bids <= count + 1.
  - done = 1 for exactly that cycle.
- Latency: result is registered and done asserts one cycle after the final bid handshake.
- start is ignored while in COLLECT; there is no abort except rst.
- Single-bid auction in second-price mode: price = 0.
- All bids zero: winner = 0, price = 0.
- Full-scale bid (2**W-1): no overflow. Comparisons are unsigned W-bit and the price is never computed arithmetically.
- bid_valid is ignored outside COLLECT; bid_ready = 0 there, so nothing is consumed.
- start asserted in the same cycle done is high (state DONE): accepted, and a new auction begins the next cycle.
- rst mid-COLLECT: abandons the auction immediately. Outputs return to reset values and the partial result is never reported.

Decomposition:
- Package seq_auction_pkg holds:
  - state enum {IDLE, COLLECT, DONE}
  - mode constants FIRST_PRICE = 0, SECOND_PRICE = 1
- Sub-module top2_update: combinational. Inputs: top1, top2, idx, bid, count. Outputs: next top1, top2, idx, with the tie rules above. It is reusable by a future multi-lane tree-of-trackers variant.
- The FSM, counters and result registers live in seq_auction.

Test Plan:
- N=2, W=8, mode=0; bids 5, 9, 3, 7 with last on 7 -> done one cycle after 4th handshake; winner=1, price=9, num_bids=4.
- Same bids, mode=1 -> winner=1, price=7.
- Tie, mode=1; bids 4, 9, 9 (last) -> winner=1, price=9; the earlier bidder wins.
- Overflow close: N=2, 4 bids 1, 2, 3, 255, bid_last never asserted -> auto-close after 4th; winner=3; price=255 (mode 0) or 3 (mode 1); bid_ready=0 in DONE.
- Single bid 42, mode=1 -> winner=0, price=0, num_bids=1.
- Reset and back-to-back:
  - rst pulsed after 2 bids: no done; all outputs return to 0.
  - Then start in the same cycle as done: the next auction runs and the previous result holds until the new done.

Source files
------------

// File: rtl/seq_auction_pkg.sv
// seq_auction_pkg: shared FSM state type and pricing-mode encodings for the auction engine
package seq_auction_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  localparam logic FIRST_PRICE = 1'b0;
  localparam logic SECOND_PRICE = 1'b1;
endpackage

// File: rtl/seq_auction_if.sv
// seq_auction_if: bid stream, control and result bundle between bid source and auction engine
interface seq_auction_if #(parameter int N = 2, parameter int W = 8);
  logic start;
  logic mode;
  logic bid_valid;
  logic bid_ready;
  logic [W-1:0] bid;
  logic bid_last;
  logic busy;
  logic done;
  logic [N-1:0] winner;
  logic [W-1:0] price;
  logic [N:0] num_bids;
  modport master (
    output start, mode, bid_valid, bid, bid_last,
    input bid_ready, busy, done, winner, price, num_bids
  );
  modport slave (
    input start, mode, bid_valid, bid, bid_last,
    output bid_ready, busy, done, winner, price, num_bids
  );
endinterface

// File: rtl/seq_auction_top2_update.sv
// top2_update: folds one bid into a running best/second-best tracker; ties keep the earlier winner
module top2_update #(parameter int N = 2, parameter int W = 8) (
  input  logic [W-1:0] top1,
  input  logic [W-1:0] top2,
  input  logic [N-1:0] idx,
  input  logic [W-1:0] bid,
  input  logic [N-1:0] count,
  output logic [W-1:0] top1_n,
  output logic [W-1:0] top2_n,
  output logic [N-1:0] idx_n
);
  // a strictly higher bid takes the lead; an equal one only raises the runner-up price
  always_comb begin
    top1_n = bid > top1 ? bid : top1;
    top2_n = bid > top1 ? top1 : (bid > top2 ? bid : top2);
    idx_n = bid > top1 ? count : idx;
  end
endmodule

// File: rtl/seq_auction.sv
// seq_auction: sequential sealed-bid auction, first-price or second-price result on close
module seq_auction
  import seq_auction_pkg::*;
#(parameter int N = 2, parameter int W = 8) (
  input logic clk,
  input logic rst,
  seq_auction_if.slave bus
);
  localparam logic [N:0] LAST_IDX = (N+1)'((1 << N) - 1);
  state_t state, state_n;
  logic [W-1:0] top1, top2, top1_n, top2_n, price_r;
  logic [N-1:0] idx, idx_n, winner_r;
  logic [N:0] count, num_bids_r;
  logic mode_r, done_r, accept, close, start_ok;
  assign start_ok = bus.start && state != COLLECT;
  assign accept = bus.bid_valid && state == COLLECT;
  assign close = accept && (bus.bid_last || count == LAST_IDX);
  assign bus.bid_ready = state == COLLECT;
  assign bus.busy = state == COLLECT;
  assign bus.done = done_r;
  assign bus.winner = winner_r;
  assign bus.price = price_r;
  assign bus.num_bids = num_bids_r;
  top2_update #(.N(N), .W(W)) u_upd (
    .top1(top1),
    .top2(top2),
    .idx(idx),
    .bid(bus.bid),
    .count(count[N-1:0]),
    .top1_n(top1_n),
    .top2_n(top2_n),
    .idx_n(idx_n)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // start opens an auction from IDLE or DONE; the closing bid moves to DONE
  always_comb begin
    state_n = state;
    if (start_ok) state_n = COLLECT;
    else if (close) state_n = DONE;
  end
  // tracker, counter and registered result; the closing bid is folded into the result
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      top1 <= '0;
      top2 <= '0;
      idx <= '0;
      count <= '0;
      mode_r <= FIRST_PRICE;
      done_r <= 1'b0;
      winner_r <= '0;
      price_r <= '0;
      num_bids_r <= '0;
    end else begin
      done_r <= close;
      if (start_ok) begin
        top1 <= '0;
        top2 <= '0;
        idx <= '0;
        count <= '0;
        mode_r <= bus.mode;
      end else if (accept) begin
        top1 <= top1_n;
        top2 <= top2_n;
        idx <= idx_n;
        count <= count + (N+1)'(1);
      end
      if (close) begin
        winner_r <= idx_n;
        price_r <= mode_r == SECOND_PRICE ? top2_n : top1_n;
        num_bids_r <= count + (N+1)'(1);
      end
    end
endmodule

// File: tb/tb_seq_auction.sv
// tb_seq_auction: directed auctions with a result scoreboard checked by an independent monitor
module tb_seq_auction;
  localparam int N = 2;
  localparam int W = 8;
  typedef struct packed {
    logic [N-1:0] w;
    logic [W-1:0] p;
    logic [N:0] n;
  } res_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  res_t exp_q[$];
  int errors = 0;
  int checks = 0;
  seq_auction_if #(.N(N), .W(W)) ifc();
  seq_auction #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(ifc));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  // monitor: every done pulse must match the oldest expected result
  always @(negedge clk)
    if (!rst && ifc.done) begin
      res_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        e = exp_q.pop_front();
        chk("winner", ifc.winner, e.w);
        chk("price", ifc.price, e.p);
        chk("num_bids", ifc.num_bids, e.n);
      end
    end
  task automatic start_auction(input logic m);
    ifc.start = 1'b1;
    ifc.mode = m;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask
  task automatic feed(input logic [31:0] v, input int n, input bit lst, input bit expect_done);
    for (int i = 0; i < n; i++) begin
      ifc.bid_valid = 1'b1;
      ifc.bid = v[8*i +: 8];
      ifc.bid_last = lst && i == n - 1;
      chk("bid_ready_collect", ifc.bid_ready, 1);
      @(negedge clk);
    end
    ifc.bid_valid = 1'b0;
    ifc.bid_last = 1'b0;
    if (expect_done) chk("done_latency", ifc.done, 1);
  endtask
  task automatic auction(input logic m, input logic [31:0] v, input int n, input bit lst,
                         input logic [N-1:0] w, input logic [W-1:0] p, input logic [N:0] nb);
    exp_q.push_back({w, p, nb});
    start_auction(m);
    feed(v, n, lst, 1'b1);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bid_ready"}, ifc.bid_ready, 0);
    chk({tag, "_busy"}, ifc.busy, 0);
    chk({tag, "_done"}, ifc.done, 0);
    chk({tag, "_winner"}, ifc.winner, 0);
    chk({tag, "_price"}, ifc.price, 0);
    chk({tag, "_num_bids"}, ifc.num_bids, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    ifc.start = 1'b0;
    ifc.mode = 1'b0;
    ifc.bid_valid = 1'b0;
    ifc.bid = '0;
    ifc.bid_last = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    auction(1'b0, 32'h07030905, 4, 1'b1, 2'd1, 8'd9, 3'd4);
    auction(1'b1, 32'h07030905, 4, 1'b1, 2'd1, 8'd7, 3'd4);
    auction(1'b1, 32'h00090904, 3, 1'b1, 2'd1, 8'd9, 3'd3);
    auction(1'b0, 32'hFF030201, 4, 1'b0, 2'd3, 8'd255, 3'd4);
    chk("bid_ready_in_done", ifc.bid_ready, 0);
    chk("busy_in_done", ifc.busy, 0);
    ifc.bid_valid = 1'b1;
    ifc.bid = 8'd77;
    @(negedge clk);
    ifc.bid_valid = 1'b0;
    chk("idle_bid_no_done", ifc.done, 0);
    chk("idle_bid_winner_hold", ifc.winner, 3);
    chk("idle_bid_price_hold", ifc.price, 255);
    auction(1'b1, 32'hFF030201, 4, 1'b0, 2'd3, 8'd3, 3'd4);
    auction(1'b1, 32'h0000002A, 1, 1'b1, 2'd0, 8'd0, 3'd1);
    start_auction(1'b0);
    feed(32'h00001410, 2, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    auction(1'b0, 32'h0032C803, 3, 1'b1, 2'd1, 8'd200, 3'd3);
    exp_q.push_back({2'd0, 8'd0, 3'd3});
    start_auction(1'b1);
    chk("b2b_busy", ifc.busy, 1);
    chk("b2b_winner_hold", ifc.winner, 1);
    chk("b2b_price_hold", ifc.price, 200);
    chk("b2b_num_bids_hold", ifc.num_bids, 3);
    feed(32'h00000000, 3, 1'b1, 1'b1);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
